// File: rtl/cpu_mem_bridge.sv
// Bridges single outstanding CPU loads/stores (8..48 bit) onto a 16-bit valid/ready memory bus,
// splitting them into halfword beats and stalling the CPU through cpu_enable until completion.
module cpu_mem_bridge #(
   parameter int ADDR_W    = 32,
   parameter int RD_DATA_W = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req_rd,
   input  logic                 cpu_req_wr,
   input  logic [1:0]           cpu_req_size,
   input  logic [ADDR_W-1:0]    cpu_req_addr,
   input  logic [47:0]          cpu_wr_data,
   output logic [RD_DATA_W-1:0] cpu_data_in,
   output logic                 cpu_enable,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_we,
   output logic [ADDR_W-1:0]    mem_req_addr,
   output logic [1:0]           mem_req_be,
   output logic [15:0]          mem_wr_data,
   input  logic                 mem_rd_valid,
   input  logic [15:0]          mem_rd_data,
   output logic                 misalign_err,
   output logic                 proto_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   state_t                 state;
   logic [1:0]             size_q;
   logic                   rd_q;
   logic [1:0]             beat_idx;
   logic [ADDR_W-1:0]      addr_q;
   logic [47:0]            wdata_q;
   logic [RD_DATA_W-1:0]   rd_buf;
   logic [RD_DATA_W-1:0]   rd_merge;
   logic                   req_any;
   logic                   last_beat;

   function automatic logic [1:0] beat_count(input logic [1:0] size);
      case (size)
         2'd2:    return 2'd2;
         2'd3:    return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0] idx);
      return {a[ADDR_W-1:1], 1'b0} + ADDR_W'({idx, 1'b0});
   endfunction

   function automatic logic [1:0] beat_be(input logic [1:0] size, input logic a0);
      if (size == 2'd0)
         return a0 ? 2'b10 : 2'b01;
      return 2'b11;
   endfunction

   // Byte writes drive the same byte on both lanes; the enables pick the real one.
   function automatic logic [15:0] beat_wdata(input logic [47:0] w, input logic [1:0] size,
                                              input logic [1:0] idx);
      if (size == 2'd0)
         return {w[7:0], w[7:0]};
      case (idx)
         2'd0:    return w[15:0];
         2'd1:    return w[31:16];
         default: return w[47:32];
      endcase
   endfunction

   assign req_any    = cpu_req_rd | cpu_req_wr;
   assign last_beat  = (beat_idx == (beat_count(size_q) - 2'd1));
   assign cpu_enable = ((state == IDLE) && !req_any) || (state == DONE);

   always_comb begin
      rd_merge = rd_buf;
      if (size_q == 2'd0) begin
         rd_merge = RD_DATA_W'(addr_q[0] ? mem_rd_data[15:8] : mem_rd_data[7:0]);
      end else begin
         case (beat_idx)
            2'd0:    rd_merge[15:0]  = mem_rd_data;
            2'd1:    rd_merge[31:16] = mem_rd_data;
            default: rd_merge[47:32] = mem_rd_data;
         endcase
      end
   end

   // Request payload and read assembly buffer; cleared at acceptance so unused upper beats read as 0.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_any) begin
         addr_q  <= cpu_req_addr;
         wdata_q <= cpu_wr_data;
         rd_buf  <= '0;
      end else if (state == WAIT_RD && mem_rd_valid) begin
         rd_buf  <= rd_merge;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         size_q        <= 2'd0;
         rd_q          <= 1'b0;
         beat_idx      <= 2'd0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_be    <= 2'b00;
         mem_wr_data   <= 16'h0000;
         cpu_data_in   <= '0;
         misalign_err  <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         proto_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  size_q    <= cpu_req_size;
                  rd_q      <= cpu_req_rd;
                  beat_idx  <= 2'd0;
                  proto_err <= cpu_req_rd & cpu_req_wr;
                  if (cpu_req_size != 2'd0 && cpu_req_addr[0]) begin
                     misalign_err <= 1'b1;
                     state        <= DONE;
                  end else begin
                     state         <= ISSUE;
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= !cpu_req_rd;
                     mem_req_addr  <= beat_addr(cpu_req_addr, 2'd0);
                     mem_req_be    <= beat_be(cpu_req_size, cpu_req_addr[0]);
                     mem_wr_data   <= beat_wdata(cpu_wr_data, cpu_req_size, 2'd0);
                  end
               end
            end
            ISSUE: begin
               // Valid low here means a bubble after the previous beat: present the next one.
               if (!mem_req_valid) begin
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= !rd_q;
                  mem_req_addr  <= beat_addr(addr_q, beat_idx);
                  mem_req_be    <= beat_be(size_q, addr_q[0]);
                  mem_wr_data   <= beat_wdata(wdata_q, size_q, beat_idx);
               end else if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (rd_q)
                     state <= WAIT_RD;
                  else if (last_beat)
                     state <= DONE;
                  else
                     beat_idx <= beat_idx + 2'd1;
               end
            end
            WAIT_RD: begin
               if (mem_rd_valid) begin
                  if (last_beat) begin
                     cpu_data_in <= rd_merge;
                     state       <= DONE;
                  end else begin
                     beat_idx <= beat_idx + 2'd1;
                     state    <= ISSUE;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomized and directed bench for cpu_mem_bridge: a bus responder drives ready/read data and
// every beat and completion is compared against a request-level model of the bridge.
module tb_cpu_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req_rd = 1'b0;
   logic        cpu_req_wr = 1'b0;
   logic [1:0]  cpu_req_size = 2'd0;
   logic [31:0] cpu_req_addr = 32'h0;
   logic [47:0] cpu_wr_data = 48'h0;
   logic [47:0] cpu_data_in;
   logic        cpu_enable;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [1:0]  mem_req_be;
   logic [15:0] mem_wr_data;
   logic        mem_rd_valid = 1'b0;
   logic [15:0] mem_rd_data = 16'h0;
   logic        misalign_err;
   logic        proto_err;

   int          vectors = 0;
   int          miscompares = 0;
   logic [47:0] model_data = 48'h0;

   cpu_mem_bridge #(.ADDR_W(32), .RD_DATA_W(48)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_rd(cpu_req_rd), .cpu_req_wr(cpu_req_wr), .cpu_req_size(cpu_req_size),
      .cpu_req_addr(cpu_req_addr), .cpu_wr_data(cpu_wr_data), .cpu_data_in(cpu_data_in),
      .cpu_enable(cpu_enable), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be),
      .mem_wr_data(mem_wr_data), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .misalign_err(misalign_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, mem_req_valid, 0);
      check_eq({tag, "_we"},    mem_req_we, 0);
      check_eq({tag, "_addr"},  mem_req_addr, 0);
      check_eq({tag, "_be"},    mem_req_be, 0);
      check_eq({tag, "_wdata"}, mem_wr_data, 0);
      check_eq({tag, "_cpu_data"}, cpu_data_in, 0);
      check_eq({tag, "_misalign"}, misalign_err, 0);
      check_eq({tag, "_proto"}, proto_err, 0);
   endtask

   // One CPU access; abort_beat >= 0 asserts rst while that read beat is waiting for data.
   task automatic run_txn(input bit rd, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [47:0] wdata,
                          input logic [47:0] rdata, input int rdy_dly, input int lat,
                          input int abort_beat, output int en_low);
      bit          is_rd, mis, done;
      int          n, bi, wait_cnt, lat_cnt, mis_cnt, pro_cnt;
      logic [31:0] ea [3];
      logic [1:0]  eb;
      logic [15:0] ed [3];
      logic [47:0] exp_rd;
      is_rd = rd;
      mis   = (size != 2'd0) && (addr % 2 == 1);
      n     = mis ? 0 : (size == 2'd3) ? 3 : (size == 2'd2) ? 2 : 1;
      eb    = (size == 2'd0) ? ((addr % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
      for (int i = 0; i < 3; i++) begin
         ea[i] = (addr - (addr % 2)) + 32'(2 * i);
         ed[i] = (size == 2'd0) ? {wdata[7:0], wdata[7:0]} : 16'(wdata >> (16 * i));
      end
      exp_rd = model_data;
      if (is_rd && !mis) begin
         if (size == 2'd0)
            exp_rd = (addr % 2 == 1) ? 48'(rdata[15:8]) : 48'(rdata[7:0]);
         else
            exp_rd = rdata & ((48'h1 << (16 * n)) - 48'h1) | ((n == 3) ? rdata : 48'h0);
      end
      bi = 0; wait_cnt = 0; lat_cnt = 0; mis_cnt = 0; pro_cnt = 0; done = 0; en_low = 0;
      @(posedge clk); #1;
      cpu_req_rd = rd; cpu_req_wr = wr; cpu_req_size = size;
      cpu_req_addr = addr; cpu_wr_data = wdata;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         mem_req_ready = 1'b0;
         mem_rd_valid  = 1'b0;
         mem_rd_data   = 16'($urandom);
         if (misalign_err) mis_cnt++;
         if (proto_err)    pro_cnt++;
         if (cpu_enable) begin
            done = 1;
            break;
         end
         en_low++;
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               if (abort_beat == bi - 1) begin
                  rst = 1'b1;
                  #1;
                  model_data = 48'h0;
                  check_reset_outputs("async_rst");
                  cpu_req_rd = 1'b0; cpu_req_wr = 1'b0;
                  @(posedge clk); #1;
                  rst = 1'b0;
                  @(negedge clk);
                  mem_rd_valid = 1'b1;
                  mem_rd_data  = 16'hBEEF;
                  @(negedge clk);
                  mem_rd_valid = 1'b0;
                  check_eq("late_rd_data", cpu_data_in, 0);
                  check_eq("late_rd_valid", mem_req_valid, 0);
                  check_eq("late_rd_enable", cpu_enable, 1);
                  return;
               end
               mem_rd_valid = 1'b1;
               mem_rd_data  = 16'(rdata >> (16 * (bi - 1)));
            end
         end
         if (mem_req_valid) begin
            if (bi >= n) begin
               check_eq("extra_beat", mem_req_valid, 0);
               break;
            end
            check_eq("beat_addr",  mem_req_addr, ea[bi]);
            check_eq("beat_be",    mem_req_be, eb);
            check_eq("beat_we",    mem_req_we, !is_rd);
            if (!is_rd) check_eq("beat_wdata", mem_wr_data, ed[bi]);
            if (wait_cnt >= rdy_dly) begin
               mem_req_ready = 1'b1;
               bi++;
               wait_cnt = 0;
               if (is_rd) lat_cnt = lat;
            end else begin
               wait_cnt++;
            end
         end
      end
      check_eq("done_seen", done, 1);
      check_eq("beat_total", bi, n);
      check_eq("cpu_data", cpu_data_in, exp_rd);
      check_eq("misalign_pulse", mis_cnt, mis);
      check_eq("proto_pulse", pro_cnt, rd & wr);
      model_data = exp_rd;
      cpu_req_rd = 1'b0; cpu_req_wr = 1'b0;
      @(negedge clk);
      check_eq("idle_enable", cpu_enable, 1);
      check_eq("idle_valid", mem_req_valid, 0);
      check_eq("misalign_len", misalign_err, 0);
      check_eq("proto_len", proto_err, 0);
   endtask

   initial begin
      int          el;
      int          r;
      bit          rd, wr;
      logic [1:0]  size;
      logic [31:0] addr;
      #22;
      check_reset_outputs("reset");
      check_eq("reset_enable", cpu_enable, 1);
      @(posedge clk); #1;
      rst = 1'b0;

      run_txn(1, 0, 2'd3, 32'h100, 48'h0, 48'h333322221111, 0, 1, -1, el);
      check_eq("rd48_stall_cycles", el, 9);
      check_eq("rd48_value", cpu_data_in, 48'h333322221111);
      run_txn(0, 1, 2'd2, 32'h20, 48'h0000DEADBEEF, 48'h0, 3, 1, -1, el);
      run_txn(1, 0, 2'd0, 32'h7, 48'h0, 48'hAB12, 1, 2, -1, el);
      check_eq("byte_rd_value", cpu_data_in, 48'h0000000000AB);
      run_txn(0, 1, 2'd0, 32'h7, 48'h5C, 48'h0, 0, 1, -1, el);
      run_txn(1, 0, 2'd1, 32'h3, 48'h0, 48'h0, 0, 1, -1, el);
      check_eq("misalign_stall_cycles", el, 1);
      run_txn(1, 1, 2'd1, 32'h40, 48'h0, 48'h9A9A, 0, 1, -1, el);
      run_txn(1, 0, 2'd3, 32'hFFFFFFFC, 48'h0, 48'h123456789ABC, 2, 3, -1, el);
      run_txn(1, 0, 2'd3, 32'h200, 48'h0, 48'hCCCCBBBBAAAA, 0, 2, 1, el);
      run_txn(1, 0, 2'd1, 32'h300, 48'h0, 48'h5A5A, 0, 1, -1, el);
      check_eq("post_rst_value", cpu_data_in, 48'h5A5A);

      for (int t = 0; t < 40; t++) begin
         r    = $urandom_range(0, 9);
         rd   = (r < 5);
         wr   = (r >= 4);
         size = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
         if (t % 8 == 0) addr[31:3] = '1;
         run_txn(rd, wr, size, addr, 48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
                 $urandom_range(0, 3), $urandom_range(1, 3), -1, el);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits between the CPU core and the 16-bit instruction/data memory bus.
- Accepts the CPU's single outstanding read/write request (8/16/32/48-bit) and splits it into 1-3 halfword bus beats with a valid/ready handshake.
- Assembles read beats into the CPU's 48-bit data input.
- Holds the CPU stalled through its enable input until the access completes.

Parameters:
ADDR_W, 32, byte-address width of CPU and memory bus
RD_DATA_W, 48, width of assembled CPU data (3 halfword beats; fixed, not meant to be changed)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req_rd  in  1  CPU requests a read
cpu_req_wr  in  1  CPU requests a write
cpu_req_size  in  2  0=8-bit, 1=16-bit, 2=32-bit, 3=48-bit
cpu_req_addr  in  ADDR_W  byte address
cpu_wr_data  in  48  write data, bits [7:0]/[15:0]/[31:0]/[47:0] used per size
cpu_data_in  out  48  assembled read data to CPU
cpu_enable  out  1  CPU clock-enable (stall when 0)
mem_req_valid  out  1  bus beat request valid
mem_req_ready  in  1  bus accepts beat
mem_req_we  out  1  1=write beat, 0=read beat
mem_req_addr  out  ADDR_W  halfword-aligned beat address (bit0=0)
mem_req_be  out  2  byte enables, bit0=low byte (even address)
mem_wr_data  out  16  write beat data
mem_rd_valid  in  1  read beat data valid
mem_rd_data  in  16  read beat data
misalign_err  out  1  one-cycle pulse: misaligned multi-byte request
proto_err  out  1  one-cycle pulse: rd and wr asserted together

Behaviour:
- Reset (async, any state): state=IDLE; mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_be=0, mem_wr_data=0, cpu_data_in=0, misalign_err=0, proto_err=0. An in-flight beat is abandoned. Late mem_rd_valid is ignored because it is only honoured in WAIT_RD.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- cpu_enable is combinational: 1 when (state==IDLE and !(cpu_req_rd|cpu_req_wr)) or state==DONE; 0 otherwise. The CPU therefore never advances on the acceptance edge. All other outputs are registered.
- IDLE:
  - Any of rd/wr high is accepted at the edge. The bridge latches size, addr, wr_data and direction.
  - rd&wr together: treated as read; proto_err pulses one cycle.
  - Beat count: size 0 -> 1, size 1 -> 1, size 2 -> 2, size 3 -> 3.
  - size!=0 with addr[0]=1: no bus beats; misalign_err pulses; go to DONE; cpu_data_in unchanged.
  - Otherwise go to ISSUE with beat index 0.
- ISSUE:
  - mem_req_valid=1. addr/be/we/wr_data stay stable until the edge where valid&ready.
  - Beat i address = (latched addr with bit0 cleared) + 2*i, wrapping modulo 2^ADDR_W.
  - Byte access: be = addr[0] ? 2'b10 : 2'b01; write data byte is replicated in both lanes.
  - Halfword beats: be=2'b11; beat i write data = cpu_wr_data[16i+15:16i].
  - On handshake:
    - Write: last beat -> DONE, else stay in ISSUE with next beat.
    - Read: -> WAIT_RD.
  - mem_req_valid drops on the handshake edge and re-asserts the following cycle for the next beat (no back-to-back beats).
- WAIT_RD:
  - On mem_rd_valid, store the beat.
    - Byte read: selected lane zero-extended into cpu_data_in[7:0], bits [47:8]=0.
    - Halfword beat i: data goes to cpu_data_in[16i+15:16i]. Bits above the last beat are cleared at completion.
  - Last beat -> DONE, else -> ISSUE with the next beat.
  - Minimum read latency is 1 cycle after handshake; mem_rd_valid in any other state is ignored.
- DONE: exactly one cycle with cpu_enable=1. The CPU consumes cpu_data_in and updates its request outputs. Request inputs are ignored. DONE -> IDLE unconditionally.
- Back-to-back requests: a request still asserted in the IDLE cycle after DONE is a new request.
- cpu_data_in holds its value outside read completion; writes never modify it.
- Only one transaction is outstanding; mem_req_ready held low stalls indefinitely with cpu_enable=0.

Test Plan:
- 48-bit read at 0x100, ready=1, read latency 1, data 0x1111/0x2222/0x3333: beats at 0x100/0x102/0x104 with be=11; cpu_data_in=0x333322221111; cpu_enable low 9 cycles, then high exactly in DONE.
- 32-bit write at 0x20, wr_data=0x0000DEADBEEF, ready delayed 3 cycles per beat: beats 0x20/BEEF, 0x22/DEAD with we=1; payload stable while ready=0; cpu_data_in unchanged.
- Byte read at 0x7: beat addr 0x6, be=10, rd_data=0xAB12 -> cpu_data_in=0x0000000000AB. Byte write at 0x7, data 0x5C: mem_wr_data=0x5C5C, be=10.
- 16-bit read at 0x3: no mem_req_valid; misalign_err pulses once; DONE next cycle; cpu_data_in unchanged. rd&wr both high at aligned 0x40 size 1: read beat at 0x40, proto_err pulses.
- 48-bit read at 0xFFFFFFFC: beat addresses 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000.
- rst asserted mid-beat 2 of a 48-bit read (in WAIT_RD): outputs zero immediately without a clock; a subsequent mem_rd_valid is ignored; the next request proceeds normally from IDLE.
